// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the control unit that drives it.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [5:0] OP_LW = 6'b110000;
  localparam logic [5:0] OP_SW = 6'b110001;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter preload on request acceptance; zero wait states bypass WAIT entirely.
  function automatic cnt_t wait_load(input int wait_cyc);
    return (wait_cyc == 0) ? {CNT_W{1'b0}} : cnt_t'(wait_cyc - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered, hold-until-next-read output.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-3:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Array write; contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (RST && we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, otherwise updated only by a completing read.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder (RD/WR strobe in, one-cycle ready out).
// Optional misaligned-access detection with err output: define DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  state_t            state_r, state_nxt_s;
  cnt_t              cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              is_wr_r;
  logic              ready_r, ready_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              accept_s, align_ok_s;
  logic              mem_we_s, mem_re_s;
  logic              unused_addr_s;

  assign accept_s      = (state_r == ST_IDLE) && (RD || WR);
  assign unused_addr_s = ^addr[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_r, err_nxt_s;
  assign align_ok_s = (addr_r[1:0] == 2'b00);
  assign err        = err_r;

  // Misalignment flag register, pulsed alongside ready.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
    end
  end

  // Misalignment flag is raised only by a completing access.
  always_comb begin
    err_nxt_s = 1'b0;
    if (state_r == ST_ACCESS) begin
      err_nxt_s = ~align_ok_s;
    end else begin
      err_nxt_s = 1'b0;
    end
  end
`else
  logic unused_align_s;
  assign align_ok_s     = 1'b1;
  assign unused_align_s = ^addr_r[1:0];
`endif

  // State, wait counter and status output registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Request capture; WR wins when both strobes are high.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
      is_wr_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= addr[ADDR_W-1:0];
      wdata_r <= wdata;
      is_wr_r <= WR;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
          cnt_nxt_s   = wait_load(WAIT_CYC);
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_ACCESS;
          cnt_nxt_s   = cnt_r;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r - cnt_t'(1);
        end
      end
      ST_ACCESS: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Array strobes and next values of the status outputs.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    ready_nxt_s = 1'b0;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          busy_nxt_s = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_WAIT: begin
        busy_nxt_s = 1'b1;
      end
      ST_ACCESS: begin
        mem_we_s    = is_wr_r & align_ok_s;
        mem_re_s    = ~is_wr_r & align_ok_s;
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .CLK  (CLK),
    .RST  (RST),
    .we   (mem_we_s),
    .re   (mem_re_s),
    .idx  (addr_r[ADDR_W-1:2]),
    .wdata(wdata_r),
    .rdata(rdata)
  );

  assign ready = ready_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        CLK;
  logic        rst0, rd0, wr0, ready0, busy0;
  logic        rst2, rd2, wr2, ready2, busy2;
  logic [31:0] addr0, wdata0, rdata0;
  logic [31:0] addr2, wdata2, rdata2;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err0, err2;
`endif
  logic        prev0 = 1'b0;
  logic        prev2 = 1'b0;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q2[$];

  dmem_responder #(.ADDR_W(8), .WAIT_CYC(0)) u_dut0 (
    .CLK(CLK), .RST(rst0), .RD(rd0), .WR(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err(err0)
`endif
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYC(2)) u_dut2 (
    .CLK(CLK), .RST(rst2), .RD(rd2), .WR(wr2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .busy(busy2)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err(err2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    prev0 <= ready0;
    prev2 <= ready2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_item(input int sel, input logic [31:0] rd, input logic er,
                          input logic bsy, input logic prev);
    exp_t e;
    int   n;
    n = (sel == 0) ? q0.size() : q2.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ready dut%0d: got ready=1 required no pending access (cycle %0d)",
               sel, cyc);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else          e = q2.pop_front();
      check($sformatf("rdata_dut%0d", sel), rd, e.rdata);
      check($sformatf("ready_cycle_dut%0d", sel), cyc, e.cyc);
      check($sformatf("busy_at_ready_dut%0d", sel), {31'd0, bsy}, 32'd0);
      check($sformatf("ready_single_dut%0d", sel), {31'd0, prev}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      check($sformatf("err_dut%0d", sel), {31'd0, er}, {31'd0, e.err});
`else
      if (er !== 1'b0) $display("note: unexpected err value");
`endif
    end
  endtask

  // Monitor: every ready pulse is matched against the oldest expected completion.
  always @(negedge CLK) begin
`ifdef DMEM_ALIGN_CHECK_EN
    if (ready0 === 1'b1) mon_item(0, rdata0, err0, busy0, prev0);
    if (ready2 === 1'b1) mon_item(2, rdata2, err2, busy2, prev2);
`else
    if (ready0 === 1'b1) mon_item(0, rdata0, 1'b0, busy0, prev0);
    if (ready2 === 1'b1) mon_item(2, rdata2, 1'b0, busy2, prev2);
`endif
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? (ready0 === 1'b1) : (ready2 === 1'b1);
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy0 : busy2;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
    end
  endtask

  // Issue at the current negedge, hold the strobe until ready, then drop it.
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    logic got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc + sel + 2;
    if (sel == 0) q0.push_back(e);
    else          q2.push_back(e);
    drive(sel, rd, wr, a, d);
    @(negedge CLK);
    check($sformatf("busy_after_accept_dut%0d", sel), {31'd0, bsy(sel)}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rdy(sel)) got = 1'b1;
      else          @(negedge CLK);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout dut%0d: got no ready required ready within 40 cycles", sel);
    end
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; rst2 = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_ready0", {31'd0, ready0}, 32'd0);
    check("reset_busy0",  {31'd0, busy0},  32'd0);
    check("reset_rdata2", rdata2, 32'h0);
    check("reset_ready2", {31'd0, ready2}, 32'd0);
    check("reset_busy2",  {31'd0, busy2},  32'd0);
    rst0 = 1'b1; rst2 = 1'b1;

    // Two wait states: basic write/read
    do_req(2, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    do_req(2, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0);
    // Address wrap modulo 256
    do_req(2, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    do_req(2, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0);
    // RD+WR together: write wins, rdata held
    do_req(2, 1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h1234_5678, 1'b0);
    do_req(2, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0);
    do_req(2, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 32'hCAFE_F00D, 1'b0);

    // Reset during WAIT of a write: aborted, no ready
    drive(2, 1'b0, 1'b1, 32'h0000_0010, 32'h2222_2222);
    @(negedge CLK);
    check("abort_busy", {31'd0, busy2}, 32'd1);
    rst2 = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    rst2 = 1'b1;
    check("abort_rdata_cleared", rdata2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_ready", {31'd0, ready2}, 32'd0);
      @(negedge CLK);
    end
    do_req(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1111_1111, 1'b0);

    // Misaligned write
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(2, 1'b0, 1'b1, 32'h0000_000A, 32'hA5A5_A5A5, 32'h1111_1111, 1'b1);
    do_req(2, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0);
`else
    do_req(2, 1'b0, 1'b1, 32'h0000_000A, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0);
    do_req(2, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 1'b0);
`endif

    // Zero wait states, back-to-back
    do_req(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_AAAA, 32'h0000_0000, 1'b0);
    do_req(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_BBBB, 32'h0000_0000, 1'b0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_AAAA, 1'b0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_BBBB, 1'b0);

    repeat (4) @(negedge CLK);
    check("pending_dut0", q0.size(), 32'd0);
    check("pending_dut2", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
